// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, stability-count debounce, press/release pulses
// and acknowledgeable sticky press flags per channel. Define AUTO_REPEAT_EN for held-key auto-repeat.
module button_conditioner #(
   parameter int N_BTN         = 2,
   parameter int STABLE_CNT    = 1000000,
   parameter int CNT_W         = 24,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 10000000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic [N_BTN-1:0] evt_ack,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_evt
);

   typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   if (STABLE_CNT < 2 || (longint'(STABLE_CNT - 1) >> CNT_W) != 0) begin : g_bad_stable
      $error("STABLE_CNT must be at least 2 and STABLE_CNT-1 must fit in CNT_W bits");
   end
   if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
      $error("REPEAT_PERIOD must be in 1..REPEAT_DELAY");
   end

`ifdef AUTO_REPEAT_EN
   localparam int               REP_W      = $clog2(REPEAT_DELAY + 1);
   localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY - 1);
   // Reloading to DELAY-PERIOD makes every later pulse land PERIOD cycles after the previous one.
   localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);
`endif

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      logic [1:0]       sync;
      logic             s;
      state_t           state;
      logic [CNT_W-1:0] cnt;
      logic             level;
      logic             press;
      logic             rls;
      logic             evt;
`ifdef AUTO_REPEAT_EN
      logic [REP_W-1:0] rep;
`endif

      assign s = sync[1];

      // NOTE: every register here is updated with <= so all channel state advances on the same edge.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            sync  <= '0;
            state <= IDLE_LO;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rls   <= 1'b0;
            evt   <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep   <= '0;
`endif
         end else begin
            sync  <= {sync[0], btn_raw[i]};
            press <= 1'b0;
            rls   <= 1'b0;
            // A press visible this cycle sets the flag on the edge where an ack would clear it: set wins.
            evt   <= press | (evt & ~evt_ack[i]);
            case (state)
               IDLE_LO: begin
                  if (s) begin
                     state <= WAIT_HI;
                     cnt   <= '0;
                  end
               end
               WAIT_HI: begin
                  if (!s) begin
                     state <= IDLE_LO;
                     cnt   <= '0;
                  end else if (cnt == CNT_LAST) begin
                     state <= IDLE_HI;
                     level <= 1'b1;
                     press <= 1'b1;
`ifdef AUTO_REPEAT_EN
                     rep   <= '0;
`endif
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               IDLE_HI: begin
                  if (!s) begin
                     state <= WAIT_LO;
                     cnt   <= '0;
`ifdef AUTO_REPEAT_EN
                     rep   <= '0;
                  end else if (rep == REP_LAST) begin
                     press <= 1'b1;
                     rep   <= REP_RELOAD;
                  end else begin
                     rep <= rep + 1'b1;
`endif
                  end
               end
               WAIT_LO: begin
                  if (s) begin
                     state <= IDLE_HI;
                     cnt   <= '0;
                  end else if (cnt == CNT_LAST) begin
                     state <= IDLE_LO;
                     level <= 1'b0;
                     rls   <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= IDLE_LO;
            endcase
         end
      end

      assign btn_level[i]   = level;
      assign btn_press[i]   = press;
      assign btn_release[i] = rls;
      assign btn_evt[i]     = evt;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus randomised bouncing,
// compared every cycle against a run-length reference model of the debounce rules.
module tb_button_conditioner;

   localparam int N  = 2;
   localparam int S  = 8;
   localparam int CW = 4;
   localparam int RD = 16;
   localparam int RP = 4;

   logic         clock   = 1'b0;
   logic         reset   = 1'b1;
   logic [N-1:0] btn_raw = '0;
   logic [N-1:0] evt_ack = '0;
   logic [N-1:0] btn_level, btn_press, btn_release, btn_evt;

   int checks = 0;
   int errors = 0;

   button_conditioner #(
      .N_BTN(N), .STABLE_CNT(S), .CNT_W(CW), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clock(clock), .reset(reset), .btn_raw(btn_raw), .evt_ack(evt_ack),
      .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release), .btn_evt(btn_evt)
   );

   always #5 clock = ~clock;

   // Reference model: raw is seen two samples late; the level flips once S+1 consecutive
   // samples disagree with it. Auto-repeat counts cycles spent continuously held high.
   logic [N-1:0] m_h1, m_h2, m_lvl, m_prs, m_rel, m_evt, m_prev;
   int           m_run[N];
   int           m_held[N];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_h1 = '0; m_h2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0; m_evt = '0; m_prev = '0;
      for (int i = 0; i < N; i++) begin
         m_run[i]  = 0;
         m_held[i] = 0;
      end
   endtask

   task automatic model_edge();
      logic s;
      if (reset) begin
         model_clear();
         return;
      end
      for (int i = 0; i < N; i++) begin
         s        = m_h2[i];
         m_h2[i]  = m_h1[i];
         m_h1[i]  = btn_raw[i];
         m_evt[i] = m_prs[i] | (m_evt[i] & ~evt_ack[i]);
         m_prs[i] = 1'b0;
         m_rel[i] = 1'b0;
         if (s != m_lvl[i]) m_run[i]++;
         else m_run[i] = 0;
         if (m_run[i] == S + 1) begin
            m_lvl[i] = ~m_lvl[i];
            m_run[i] = 0;
            if (m_lvl[i]) begin
               m_prs[i]  = 1'b1;
               m_held[i] = 0;
            end else begin
               m_rel[i] = 1'b1;
            end
         end
`ifdef AUTO_REPEAT_EN
         else if (m_lvl[i] && s) begin
            if (!m_prev[i]) m_held[i] = 0;
            else m_held[i]++;
            if (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RP == 0)) m_prs[i] = 1'b1;
         end
`endif
         m_prev[i] = s;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      check("level",   btn_level,   m_lvl);
      check("press",   btn_press,   m_prs);
      check("release", btn_release, m_rel);
      check("evt",     btn_evt,     m_evt);
   endtask

   task automatic ticks(input int n);
      for (int t = 0; t < n; t++) tick();
   endtask

   initial begin
      int presses;
      int releases;
      int hold_left[N];

      model_clear();
      #1;
      check("reset_outputs", {btn_level, btn_press, btn_release, btn_evt}, '0);
      ticks(3);
      #2 reset = 1'b0;

      // Clean press on channel 0
      btn_raw = 2'b01;
      ticks(10);
      check("press_not_early", btn_level[0], 1'b0);
      tick();
      check("press_latency_level", btn_level, 2'b01);
      check("press_latency_pulse", btn_press, 2'b01);
      tick();
      check("press_one_cycle", btn_press, 2'b00);
      check("press_evt_set", btn_evt, 2'b01);
      ticks(7);

      // Release
      btn_raw = 2'b00;
      ticks(10);
      check("release_not_early", btn_level[0], 1'b1);
      tick();
      check("release_pulse", btn_release, 2'b01);
      check("release_level", btn_level, 2'b00);
      ticks(9);
      check("release_evt_kept", btn_evt, 2'b01);
      evt_ack = 2'b01;
      tick();
      evt_ack = 2'b00;
      check("ack_clears", btn_evt, 2'b00);

      // Bounce 1,0,1,0 every 3 cycles, then hold
      presses  = 0;
      releases = 0;
      for (int b = 0; b < 4; b++) begin
         btn_raw[0] = (b % 2 == 0);
         for (int t = 0; t < 3; t++) begin
            tick();
            presses  += btn_press[0];
            releases += btn_release[0];
         end
      end
      btn_raw[0] = 1'b1;
      for (int t = 0; t < 10; t++) begin
         tick();
         presses  += btn_press[0];
         releases += btn_release[0];
      end
      check("bounce_no_early_press", presses, 0);
      tick();
      check("bounce_press_latency", btn_press, 2'b01);
      presses += btn_press[0];
      ticks(2);
      check("bounce_single_press", presses, 1);
      check("bounce_no_release", releases, 0);

      // Ack race: ack during the press cycle loses, ack one cycle later clears
      evt_ack = 2'b01;
      tick();
      evt_ack = 2'b00;
      btn_raw = 2'b00;
      ticks(20);
      btn_raw = 2'b01;
      ticks(11);
      check("race_press", btn_press, 2'b01);
      evt_ack = 2'b01;
      tick();
      check("race_set_wins", btn_evt[0], 1'b1);
      tick();
      check("race_ack_later", btn_evt[0], 1'b0);
      evt_ack = 2'b00;

      // Reset in the middle of WAIT_HI
      btn_raw = 2'b00;
      ticks(20);
      btn_raw = 2'b01;
      ticks(8);
      #2 reset = 1'b1;
      #1;
      model_clear();
      check("midreset_outputs", {btn_level, btn_press, btn_release, btn_evt}, '0);
      ticks(2);
      #2 reset = 1'b0;
      ticks(10);
      check("midreset_no_early", btn_level, 2'b00);
      tick();
      check("midreset_press", btn_press, 2'b01);

      // Simultaneous press on both channels
      btn_raw = 2'b00;
      ticks(20);
      btn_raw = 2'b11;
      ticks(11);
      check("simul_press", btn_press, 2'b11);
      presses = 0;
`ifdef AUTO_REPEAT_EN
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (t == 16 || t == 20 || t == 24) check("repeat_pulse", btn_press, 2'b11);
         else if (t == 17 || t == 15) check("repeat_gap", btn_press, 2'b00);
      end
      btn_raw = 2'b00;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (btn_press != 0) presses++;
      end
      check("repeat_stops", presses, 0);
`else
      for (int t = 0; t < 30; t++) begin
         tick();
         if (btn_press != 0) presses++;
      end
      check("no_repeat", presses, 0);
      btn_raw = 2'b00;
      ticks(20);
`endif

      // Randomised bouncing and acknowledges
      for (int i = 0; i < N; i++) hold_left[i] = 0;
      for (int t = 0; t < 1500; t++) begin
         for (int i = 0; i < N; i++) begin
            if (hold_left[i] == 0) begin
               btn_raw[i]   = ~btn_raw[i];
               hold_left[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6))
                                                          : int'($urandom_range(9, 30));
            end else begin
               hold_left[i]--;
            end
         end
         evt_ack = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
